// File: rtl/fft_stream_ctrl_pkg.sv
// Shared state encodings and sizing helper for the FFT input-side control blocks.
package fft_stream_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESYNC = 3'd0,
    ST_IDLE   = 3'd1,
    ST_RUN    = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4
  } ctrl_state_e;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n <= 32'sd2) ? 32'sd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fft_stream_ctrl_if.sv
// Source stream, FFT input and frame-status signals of the FFT stream controller.
interface fft_stream_ctrl_if #(
  parameter int DATA_W = 20,
  parameter int PEND_W = 4
);
  logic              s_vld;
  logic              s_sof;
  logic [DATA_W-1:0] s_data;
  logic              s_rdy;
  logic              o_vld;
  logic [DATA_W-1:0] o_data;
  logic              o_init;
  logic              i_fft_vld;
  logic [PEND_W-1:0] o_pending;
  logic              o_flushing;
  logic              o_err_sof;
  logic              o_drop;

  modport master (
    output s_vld, s_sof, s_data, i_fft_vld,
    input  s_rdy, o_vld, o_data, o_init, o_pending, o_flushing, o_err_sof, o_drop
  );

  modport slave (
    input  s_vld, s_sof, s_data, i_fft_vld,
    output s_rdy, o_vld, o_data, o_init, o_pending, o_flushing, o_err_sof, o_drop
  );
endinterface

// File: rtl/fft_frame_tracker.sv
// Counts dereverse output beats and keeps the number of frames written but not
// yet fully emitted, saturating at the top of its range.
module fft_frame_tracker
  import fft_stream_ctrl_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int PEND_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              inc_i,
  input  logic              beat_i,
  output logic [PEND_W-1:0] pending_o,
  output logic              sat_err_o
);
  localparam int C_W = cnt_w(DEPTH);
  localparam logic [C_W-1:0]    BEAT_LAST = C_W'(DEPTH - 32'sd1);
  localparam logic [C_W-1:0]    BEAT_ONE  = C_W'(1'b1);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1'b1);

  logic [C_W-1:0]    beat_q;
  logic [PEND_W-1:0] pend_q;
  logic [PEND_W-1:0] pend_d;
  logic              dec_s;
  logic              full_s;
  logic              sat_s;

  assign dec_s  = beat_i & (beat_q == BEAT_LAST) & (pend_q != {PEND_W{1'b0}});
  assign full_s = (pend_q == {PEND_W{1'b1}});

  // Pending next state: a coincident increment and decrement cancel out.
  always_comb begin
    pend_d = pend_q;
    sat_s  = 1'b0;
    if (inc_i && !dec_s) begin
      if (full_s) begin
        sat_s = 1'b1;
      end else begin
        pend_d = pend_q + PEND_ONE;
      end
    end else if (dec_s && !inc_i) begin
      pend_d = pend_q - PEND_ONE;
    end else begin
      pend_d = pend_q;
    end
  end

  // Out-beat and pending registers, cleared together with the datapath.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      beat_q <= {C_W{1'b0}};
      pend_q <= {PEND_W{1'b0}};
    end else begin
      if (beat_i) begin
        beat_q <= beat_q + BEAT_ONE;
      end else begin
        beat_q <= beat_q;
      end
      pend_q <= pend_d;
    end
  end

  assign pending_o = pend_q;
  assign sat_err_o = sat_s;

endmodule

// File: rtl/fft_stream_ctrl.sv
// Input-side sequencer for the pipelined FFT: frame alignment, a zero flush
// frame to drain the ping-pong dereverse stage on source idle, then re-init.
module fft_stream_ctrl
  import fft_stream_ctrl_pkg::*;
#(
  parameter int DATA_W       = 20,
  parameter int DEPTH        = 128,
  parameter int IDLE_TIMEOUT = 64,
  parameter int INIT_CYCLES  = 4,
  parameter int PEND_W       = 4
) (
  input logic              mclk,
  input logic              i_init,
  fft_stream_ctrl_if.slave bus
);
  localparam int C_W = cnt_w(DEPTH);
  localparam int T_W = cnt_w(IDLE_TIMEOUT);
  localparam int I_W = cnt_w(INIT_CYCLES);
  localparam logic [C_W-1:0] CNT_LAST  = C_W'(DEPTH - 32'sd1);
  localparam logic [C_W-1:0] CNT_ONE   = C_W'(1'b1);
  localparam logic [T_W-1:0] TMR_LAST  = T_W'(IDLE_TIMEOUT - 32'sd1);
  localparam logic [T_W-1:0] TMR_ONE   = T_W'(1'b1);
  localparam logic [I_W-1:0] INIT_LAST = I_W'(INIT_CYCLES - 32'sd1);
  localparam logic [I_W-1:0] INIT_ONE  = I_W'(1'b1);

  ctrl_state_e       state_q;
  logic [C_W-1:0]    cnt_q;
  logic [T_W-1:0]    tmr_q;
  logic [I_W-1:0]    init_cnt_q;
  logic              s_rdy_q;
  logic              o_vld_q;
  logic [DATA_W-1:0] o_data_q;
  logic              o_init_q;
  logic              flushing_q;
  logic              err_sof_q;
  logic              drop_q;

  logic              accept_s;
  logic              cnt_zero_s;
  logic              frame_err_s;
  logic              frame_end_s;
  logic              resync_s;
  logic              sat_err_s;
  logic [PEND_W-1:0] pending_s;

  assign accept_s    = bus.s_vld & s_rdy_q;
  assign cnt_zero_s  = (cnt_q == {C_W{1'b0}});
  // sof is legal exactly when cnt==0, so any disagreement is a framing error.
  assign frame_err_s = (state_q == ST_RUN) & accept_s & (bus.s_sof ^ cnt_zero_s);
  assign frame_end_s = (state_q == ST_RUN) & accept_s & ~frame_err_s & (cnt_q == CNT_LAST);
  assign resync_s    = (state_q == ST_RESYNC);

  fft_frame_tracker #(
    .DEPTH  (DEPTH),
    .PEND_W (PEND_W)
  ) u_tracker (
    .clk_i     (mclk),
    .rst_i     (i_init),
    .clr_i     (resync_s),
    .inc_i     (frame_end_s),
    .beat_i    (bus.i_fft_vld),
    .pending_o (pending_s),
    .sat_err_o (sat_err_s)
  );

  // Control FSM; every block output is a register updated here.
  always_ff @(posedge mclk) begin
    if (i_init) begin
      state_q    <= ST_RESYNC;
      cnt_q      <= {C_W{1'b0}};
      tmr_q      <= {T_W{1'b0}};
      init_cnt_q <= {I_W{1'b0}};
      s_rdy_q    <= 1'b0;
      o_vld_q    <= 1'b0;
      o_data_q   <= {DATA_W{1'b0}};
      o_init_q   <= 1'b1;
      flushing_q <= 1'b0;
      err_sof_q  <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      o_vld_q   <= 1'b0;
      drop_q    <= 1'b0;
      err_sof_q <= sat_err_s;
      case (state_q)
        ST_RESYNC: begin
          cnt_q      <= {C_W{1'b0}};
          tmr_q      <= {T_W{1'b0}};
          flushing_q <= 1'b0;
          if (init_cnt_q == INIT_LAST) begin
            state_q    <= ST_IDLE;
            init_cnt_q <= {I_W{1'b0}};
            o_init_q   <= 1'b0;
            s_rdy_q    <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + INIT_ONE;
            o_init_q   <= 1'b1;
            s_rdy_q    <= 1'b0;
          end
        end
        ST_IDLE: begin
          if (accept_s) begin
            tmr_q <= {T_W{1'b0}};
            if (bus.s_sof) begin
              state_q  <= ST_RUN;
              cnt_q    <= CNT_ONE;
              o_vld_q  <= 1'b1;
              o_data_q <= bus.s_data;
            end else begin
              drop_q <= 1'b1;
            end
          end else if (tmr_q != TMR_LAST) begin
            tmr_q <= tmr_q + TMR_ONE;
          end else if (pending_s != {PEND_W{1'b0}}) begin
            state_q    <= ST_FLUSH;
            s_rdy_q    <= 1'b0;
            flushing_q <= 1'b1;
            tmr_q      <= {T_W{1'b0}};
          end else begin
            tmr_q <= tmr_q;
          end
        end
        ST_RUN: begin
          if (frame_err_s) begin
            state_q    <= ST_RESYNC;
            init_cnt_q <= {I_W{1'b0}};
            o_init_q   <= 1'b1;
            s_rdy_q    <= 1'b0;
            cnt_q      <= {C_W{1'b0}};
            tmr_q      <= {T_W{1'b0}};
            err_sof_q  <= 1'b1;
          end else if (accept_s) begin
            tmr_q    <= {T_W{1'b0}};
            o_vld_q  <= 1'b1;
            o_data_q <= bus.s_data;
            cnt_q    <= (cnt_q == CNT_LAST) ? {C_W{1'b0}} : cnt_q + CNT_ONE;
          end else if (!cnt_zero_s || (tmr_q != TMR_LAST)) begin
            tmr_q <= cnt_zero_s ? tmr_q + TMR_ONE : tmr_q;
          end else begin
            state_q    <= ST_FLUSH;
            s_rdy_q    <= 1'b0;
            flushing_q <= 1'b1;
            tmr_q      <= {T_W{1'b0}};
          end
        end
        ST_FLUSH: begin
          o_vld_q  <= 1'b1;
          o_data_q <= {DATA_W{1'b0}};
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_DRAIN;
            cnt_q   <= {C_W{1'b0}};
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_DRAIN: begin
          // The flush frame itself is never waited for; re-init discards it.
          if (pending_s == {PEND_W{1'b0}}) begin
            state_q    <= ST_RESYNC;
            init_cnt_q <= {I_W{1'b0}};
            o_init_q   <= 1'b1;
            flushing_q <= 1'b0;
          end else begin
            state_q <= ST_DRAIN;
          end
        end
        default: begin
          state_q    <= ST_RESYNC;
          init_cnt_q <= {I_W{1'b0}};
          o_init_q   <= 1'b1;
          s_rdy_q    <= 1'b0;
          flushing_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_rdy      = s_rdy_q;
  assign bus.o_vld      = o_vld_q;
  assign bus.o_data     = o_data_q;
  assign bus.o_init     = o_init_q;
  assign bus.o_pending  = pending_s;
  assign bus.o_flushing = flushing_q;
  assign bus.o_err_sof  = err_sof_q;
  assign bus.o_drop     = drop_q;

endmodule

// File: tb/tb_fft_stream_ctrl.sv
// Directed self-checking bench for fft_stream_ctrl with DEPTH=8, IDLE_TIMEOUT=16, INIT_CYCLES=4.
module tb_fft_stream_ctrl;
  localparam int DATA_W = 20;
  localparam int DEPTH  = 8;
  localparam int IDLE   = 16;
  localparam int INITC  = 4;
  localparam int PEND_W = 4;

  logic mclk;
  logic i_init;
  int   n_checks;
  int   n_errors;

  fft_stream_ctrl_if #(.DATA_W(DATA_W), .PEND_W(PEND_W)) bus ();

  fft_stream_ctrl #(
    .DATA_W       (DATA_W),
    .DEPTH        (DEPTH),
    .IDLE_TIMEOUT (IDLE),
    .INIT_CYCLES  (INITC),
    .PEND_W       (PEND_W)
  ) dut (
    .mclk   (mclk),
    .i_init (i_init),
    .bus    (bus.slave)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic step();
    @(posedge mclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic sof, input logic [DATA_W-1:0] d);
    bus.s_vld  = v;
    bus.s_sof  = sof;
    bus.s_data = d;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_vld"},  bus.o_vld, 1'b0);
    chkn({tag, "_data"}, 32'(bus.o_data), 32'd0);
    chk1({tag, "_init"}, bus.o_init, 1'b1);
    chk1({tag, "_rdy"},  bus.s_rdy, 1'b0);
    chkn({tag, "_pend"}, 32'(bus.o_pending), 32'd0);
    chk1({tag, "_flush"}, bus.o_flushing, 1'b0);
    chk1({tag, "_err"},  bus.o_err_sof, 1'b0);
    chk1({tag, "_drop"}, bus.o_drop, 1'b0);
  endtask

  // Entered on the cycle o_init has just risen: expect 4 init cycles then IDLE.
  task automatic chk_resync(input string tag);
    for (int k = 1; k <= INITC; k++) begin
      step();
      chk1({tag, "_init"}, bus.o_init, k < INITC);
      chk1({tag, "_rdy"},  bus.s_rdy, k == INITC);
      chk1({tag, "_vld"},  bus.o_vld, 1'b0);
      chkn({tag, "_pend"}, 32'(bus.o_pending), 32'd0);
    end
  endtask

  task automatic send_frame(input string tag, input int base, input int exp_pend);
    for (int j = 0; j < DEPTH; j++) begin
      drive(1'b1, j == 0, 20'(base + j));
      step();
      chk1({tag, "_vld"},  bus.o_vld, 1'b1);
      chkn({tag, "_data"}, 32'(bus.o_data), 32'(base + j));
    end
    chkn({tag, "_pend"}, 32'(bus.o_pending), 32'(exp_pend));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    i_init = 1'b1;
    drive(1'b0, 1'b0, 20'd0);
    bus.i_fft_vld = 1'b0;

    // 1. Reset hold and release
    for (int k = 0; k < 3; k++) begin
      step();
      chk_reset("rst_hold");
    end
    i_init = 1'b0;
    chk_resync("rst_rel");

    // 2. Three back-to-back frames, data 1..24, then the model emits one frame
    for (int i = 0; i < 3 * DEPTH; i++) begin
      drive(1'b1, (i % DEPTH) == 0, 20'(i + 1));
      step();
      chk1("t2_vld", bus.o_vld, 1'b1);
      chkn("t2_data", 32'(bus.o_data), 32'(i + 1));
      chkn("t2_pend", 32'(bus.o_pending), 32'((i + 1) / DEPTH));
    end
    drive(1'b0, 1'b0, 20'd0);
    bus.i_fft_vld = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chkn("t2_emit_pend", 32'(bus.o_pending), (i == DEPTH - 1) ? 32'd2 : 32'd3);
      chk1("t2_emit_vld", bus.o_vld, 1'b0);
    end
    bus.i_fft_vld = 1'b0;

    // 3. Framing error: sof on beat 5
    for (int j = 0; j < 5; j++) begin
      drive(1'b1, j == 0, 20'(100 + j));
      step();
      chk1("t3_vld", bus.o_vld, 1'b1);
      chkn("t3_data", 32'(bus.o_data), 32'(100 + j));
    end
    drive(1'b1, 1'b1, 20'h00BAD);
    step();
    chk1("t3_err", bus.o_err_sof, 1'b1);
    chk1("t3_drop_vld", bus.o_vld, 1'b0);
    chkn("t3_hold", 32'(bus.o_data), 32'd104);
    chk1("t3_init", bus.o_init, 1'b1);
    chk1("t3_rdy", bus.s_rdy, 1'b0);
    drive(1'b0, 1'b0, 20'd0);
    for (int k = 1; k <= INITC; k++) begin
      step();
      chk1("t3_err_once", bus.o_err_sof, 1'b0);
      chk1("t3_rs_init", bus.o_init, k < INITC);
      chk1("t3_rs_rdy", bus.s_rdy, k == INITC);
      chkn("t3_rs_pend", 32'(bus.o_pending), 32'd0);
    end
    send_frame("t3_clean", 200, 1);

    // 4. Second frame, silence, flush, drain, re-init
    send_frame("t4_frame", 300, 2);
    drive(1'b0, 1'b0, 20'd0);
    for (int k = 1; k <= IDLE; k++) begin
      step();
      chk1("t4_tmo_flush", bus.o_flushing, k == IDLE);
      chk1("t4_tmo_rdy", bus.s_rdy, k != IDLE);
      chk1("t4_tmo_vld", bus.o_vld, 1'b0);
    end
    for (int f = 1; f <= DEPTH; f++) begin
      step();
      chk1("t4_fl_vld", bus.o_vld, 1'b1);
      chkn("t4_fl_data", 32'(bus.o_data), 32'd0);
      chk1("t4_fl_rdy", bus.s_rdy, 1'b0);
      chk1("t4_fl_flag", bus.o_flushing, 1'b1);
    end
    step();
    chk1("t4_dr_vld", bus.o_vld, 1'b0);
    chk1("t4_dr_flag", bus.o_flushing, 1'b1);
    chkn("t4_dr_pend", 32'(bus.o_pending), 32'd2);
    bus.i_fft_vld = 1'b1;
    for (int n = 1; n <= 2 * DEPTH; n++) begin
      step();
      chkn("t4_dr_cnt", 32'(bus.o_pending), 32'(2 - n / DEPTH));
      chk1("t4_dr_rdy", bus.s_rdy, 1'b0);
      chk1("t4_dr_busy", bus.o_flushing, 1'b1);
      chk1("t4_dr_noinit", bus.o_init, 1'b0);
    end
    bus.i_fft_vld = 1'b0;
    step();
    chk1("t4_end_init", bus.o_init, 1'b1);
    chk1("t4_end_flag", bus.o_flushing, 1'b0);
    chk_resync("t4_rs");

    // 5. Non-sof beats in IDLE are dropped; sof without valid is ignored
    for (int j = 0; j < 3; j++) begin
      drive(1'b1, 1'b0, 20'(85 + j));
      step();
      chk1("t5_drop", bus.o_drop, 1'b1);
      chk1("t5_vld", bus.o_vld, 1'b0);
      chk1("t5_rdy", bus.s_rdy, 1'b1);
      drive(1'b0, 1'b0, 20'd0);
      step();
      chk1("t5_drop_end", bus.o_drop, 1'b0);
    end
    drive(1'b0, 1'b1, 20'h12345);
    step();
    chk1("t5_nv_vld", bus.o_vld, 1'b0);
    chk1("t5_nv_drop", bus.o_drop, 1'b0);
    chk1("t5_nv_rdy", bus.s_rdy, 1'b1);
    chkn("t5_nv_hold", 32'(bus.o_data), 32'd0);
    drive(1'b0, 1'b0, 20'd0);

    // 6. Mid-frame stall never times out; boundary gap 15 vs 16
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, j == 0, 20'(500 + j));
      step();
      chkn("t6_a_data", 32'(bus.o_data), 32'(500 + j));
    end
    drive(1'b0, 1'b0, 20'd0);
    for (int k = 0; k < 40; k++) begin
      step();
      chk1("t6_stall_flush", bus.o_flushing, 1'b0);
      chk1("t6_stall_rdy", bus.s_rdy, 1'b1);
    end
    for (int j = 4; j < DEPTH; j++) begin
      drive(1'b1, 1'b0, 20'(500 + j));
      step();
      chk1("t6_b_vld", bus.o_vld, 1'b1);
      chkn("t6_b_data", 32'(bus.o_data), 32'(500 + j));
    end
    chkn("t6_pend1", 32'(bus.o_pending), 32'd1);
    drive(1'b0, 1'b0, 20'd0);
    for (int k = 1; k < IDLE; k++) begin
      step();
      chk1("t6_gap15_flush", bus.o_flushing, 1'b0);
      chk1("t6_gap15_rdy", bus.s_rdy, 1'b1);
    end
    send_frame("t6_frame2", 600, 2);
    drive(1'b0, 1'b0, 20'd0);
    for (int k = 1; k <= IDLE; k++) begin
      step();
      chk1("t6_gap16_flush", bus.o_flushing, k == IDLE);
    end
    for (int f = 0; f < 3; f++) begin
      step();
      chk1("t6_fl_vld", bus.o_vld, 1'b1);
      chkn("t6_fl_data", 32'(bus.o_data), 32'd0);
    end
    i_init = 1'b1;
    step();
    chk_reset("t6_rst");
    i_init = 1'b0;
    chk_resync("t6_rel");

    // 7. Pending saturates at 15; the overflowing frame end raises o_err_sof
    for (int b = 0; b < 16 * DEPTH; b++) begin
      int p;
      p = (b + 1) / DEPTH;
      if (p > 15) p = 15;
      drive(1'b1, (b % DEPTH) == 0, 20'(b));
      step();
      chkn("t7_data", 32'(bus.o_data), 32'(b));
      chkn("t7_pend", 32'(bus.o_pending), 32'(p));
      chk1("t7_err", bus.o_err_sof, b == 16 * DEPTH - 1);
    end
    drive(1'b0, 1'b0, 20'd0);
    step();
    chk1("t7_err_end", bus.o_err_sof, 1'b0);
    chkn("t7_pend_end", 32'(bus.o_pending), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
